// File: rtl/dmem_arb_pkg.sv
// rtl/dmem_arb_pkg.sv - shared state encoding and strobe constants for the data-memory arbiter
package dmem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } arb_state_e;

    localparam logic [1:0] STRB_WORD = 2'd0;
    localparam logic [1:0] STRB_BYTE = 2'd1;
    localparam logic [1:0] STRB_HALF = 2'd2;

endpackage

// File: rtl/dmem_arb_starve_ctr.sv
// rtl/dmem_arb_starve_ctr.sv - saturating count of CPU-won cycles while a DMA beat waits
module dmem_arb_starve_ctr #(
    parameter int LIMIT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic inc,
    input  logic clr,
    output logic limit_hit
);

    localparam int CNT_W = $clog2(LIMIT + 2);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign limit_hit = (cnt_q == CNT_W'(LIMIT));

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && !limit_hit) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - shares the single-port data memory between the MEM stage and a burst DMA port
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int DATA_W       = 32,
    parameter int LEN_W        = 9,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [31:0]       cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    input  logic [1:0]        cpu_strobe,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_stall,
    input  logic              dma_start,
    input  logic              dma_dir,
    input  logic [31:0]       dma_base,
    input  logic [LEN_W-1:0]  dma_len,
    input  logic [DATA_W-1:0] dma_wdata,
    input  logic              dma_wvalid,
    output logic              dma_wready,
    output logic [DATA_W-1:0] dma_rdata,
    output logic              dma_rvalid,
    output logic              dma_busy,
    output logic              dma_done,
    output logic [31:0]       mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    output logic [1:0]        mem_strobe,
    input  logic [DATA_W-1:0] mem_rdata
);

    arb_state_e        state_q, state_d;
    logic [LEN_W-1:0]  idx_q, idx_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [31:0]       base_q, base_d;
    logic              dir_q, dir_d;
    logic [DATA_W-1:0] rdata_q;
    logic              rvalid_q;

    logic run;
    logic beat_want;
    logic starve_hit;
    logic dma_grant;
    logic last_beat;

    assign run       = (state_q == RUN);
    assign beat_want = run && (!dir_q || dma_wvalid);
    assign dma_grant = beat_want && (!cpu_req || starve_hit);
    assign last_beat = (idx_q == (len_q - LEN_W'(1)));

    dmem_arb_starve_ctr #(
        .LIMIT(STARVE_LIMIT)
    ) u_starve_ctr (
        .clk      (clk),
        .rst      (rst),
        .inc      (beat_want && cpu_req && !dma_grant),
        .clr      (dma_grant || !run),
        .limit_hit(starve_hit)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        len_d   = len_q;
        base_d  = base_q;
        dir_d   = dir_q;
        case (state_q)
            IDLE: begin
                if (dma_start) begin
                    base_d  = dma_base;
                    len_d   = dma_len;
                    dir_d   = dma_dir;
                    idx_d   = '0;
                    state_d = (dma_len == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                // idx stops at len-1 so it never indexes past the burst
                if (dma_grant) begin
                    if (last_beat) begin
                        state_d = DONE;
                    end else begin
                        idx_d = idx_q + LEN_W'(1);
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // A granted DMA beat owns the port outright, so a same-cycle CPU store cannot also write.
    // The write enable is also held low during reset so an abort leaves memory untouched.
    always_comb begin
        if (dma_grant) begin
            mem_addr   = base_q + 32'(idx_q);
            mem_we     = dir_q;
            mem_strobe = STRB_WORD;
            mem_wdata  = dma_wdata;
        end else begin
            mem_addr   = cpu_addr;
            mem_we     = rst && cpu_req && cpu_we;
            mem_strobe = cpu_strobe;
            mem_wdata  = cpu_wdata;
        end
    end

    assign cpu_rdata  = mem_rdata;
    assign cpu_stall  = cpu_req && dma_grant;
    assign dma_wready = dma_grant && dir_q;
    assign dma_rdata  = rdata_q;
    assign dma_rvalid = rvalid_q;
    assign dma_busy   = (state_q == RUN) || (state_q == DONE);
    assign dma_done   = (state_q == DONE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            len_q    <= '0;
            base_q   <= '0;
            dir_q    <= 1'b0;
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            len_q    <= len_d;
            base_q   <= base_d;
            dir_q    <= dir_d;
            rvalid_q <= dma_grant && !dir_q;
            if (dma_grant && !dir_q) begin
                rdata_q <= mem_rdata;
            end
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - directed self-checking bench for dmem_arbiter with a negedge-write memory model
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_req, cpu_we;
    logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
    logic [1:0]  cpu_strobe;
    logic        cpu_stall;
    logic        dma_start, dma_dir;
    logic [31:0] dma_base;
    logic [8:0]  dma_len;
    logic [31:0] dma_wdata, dma_rdata;
    logic        dma_wvalid, dma_wready, dma_rvalid, dma_busy, dma_done;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_we;
    logic [1:0]  mem_strobe;

    logic [31:0] mem [512];
    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    dmem_arbiter #(.DATA_W(32), .LEN_W(9), .STARVE_LIMIT(4)) dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_strobe(cpu_strobe), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
        .dma_start(dma_start), .dma_dir(dma_dir), .dma_base(dma_base), .dma_len(dma_len),
        .dma_wdata(dma_wdata), .dma_wvalid(dma_wvalid), .dma_wready(dma_wready),
        .dma_rdata(dma_rdata), .dma_rvalid(dma_rvalid), .dma_busy(dma_busy), .dma_done(dma_done),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_strobe(mem_strobe),
        .mem_rdata(mem_rdata)
    );

    assign mem_rdata = mem[mem_addr[8:0]];

    always @(negedge clk) begin
        if (mem_we) begin
            case (mem_strobe)
                2'd1:    mem[mem_addr[8:0]][7:0]  <= mem_wdata[7:0];
                2'd2:    mem[mem_addr[8:0]][15:0] <= mem_wdata[15:0];
                default: mem[mem_addr[8:0]]       <= mem_wdata;
            endcase
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic start(input logic dir, input logic [31:0] base, input logic [8:0] len);
        dma_start = 1'b1;
        dma_dir   = dir;
        dma_base  = base;
        dma_len   = len;
    endtask

    initial begin
        for (int i = 0; i < 512; i++) mem[i] = 32'hDEAD_BE00;
        rst = 1'b0;
        cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0; cpu_strobe = 0;
        dma_start = 0; dma_dir = 0; dma_base = 0; dma_len = 0; dma_wdata = 0; dma_wvalid = 0;
        #2;
        chk("rst_busy", dma_busy, 0);
        chk("rst_done", dma_done, 0);
        chk("rst_rvalid", dma_rvalid, 0);
        chk("rst_rdata", dma_rdata, 0);
        chk("rst_stall", cpu_stall, 0);
        chk("rst_mem_we", mem_we, 0);
        tick();
        tick();
        rst = 1'b1;

        // write burst of 4 words at 0x10, no CPU traffic
        start(1'b1, 32'h10, 9'd4);
        dma_wvalid = 1'b1;
        #3;
        chk("t1_idle_busy", dma_busy, 0);
        tick();
        dma_start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            dma_wdata = 32'hA000_0000 + i;
            #3;
            chk("t1_we", mem_we, 1);
            chk("t1_addr", mem_addr, 32'h10 + i);
            chk("t1_wdata", mem_wdata, 32'hA000_0000 + i);
            chk("t1_strobe", mem_strobe, 0);
            chk("t1_wready", dma_wready, 1);
            chk("t1_busy", dma_busy, 1);
            chk("t1_done_low", dma_done, 0);
            tick();
        end
        dma_wvalid = 1'b0;
        #3;
        chk("t1_done", dma_done, 1);
        chk("t1_done_we", mem_we, 0);
        chk("t1_done_wready", dma_wready, 0);
        tick();
        chk("t1_after_done", dma_done, 0);
        chk("t1_after_busy", dma_busy, 0);

        // read the same 4 words back
        start(1'b0, 32'h10, 9'd4);
        tick();
        dma_start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #3;
            chk("t2_addr", mem_addr, 32'h10 + i);
            chk("t2_we", mem_we, 0);
            chk("t2_wready", dma_wready, 0);
            chk("t2_rvalid", dma_rvalid, (i > 0) ? 1 : 0);
            if (i > 0) chk("t2_rdata", dma_rdata, 32'hA000_0000 + i - 1);
            tick();
        end
        chk("t2_last_rvalid", dma_rvalid, 1);
        chk("t2_last_rdata", dma_rdata, 32'hA000_0003);
        chk("t2_done", dma_done, 1);
        tick();
        chk("t2_rvalid_off", dma_rvalid, 0);
        chk("t2_done_off", dma_done, 0);

        // CPU loads held high across a 2-word write burst: every 5th cycle is forced to DMA
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h11;
        start(1'b1, 32'h30, 9'd2);
        dma_wvalid = 1'b1;
        tick();
        dma_start = 1'b0;
        for (int k = 0; k < 10; k++) begin
            dma_wdata = 32'hC000_0000 + k;
            #3;
            if (k % 5 == 4) begin
                chk("t3_stall", cpu_stall, 1);
                chk("t3_grant_addr", mem_addr, 32'h30 + k / 5);
                chk("t3_grant_we", mem_we, 1);
                chk("t3_grant_wready", dma_wready, 1);
            end else begin
                chk("t3_nostall", cpu_stall, 0);
                chk("t3_cpu_addr", mem_addr, 32'h11);
                chk("t3_cpu_rdata", cpu_rdata, 32'hA000_0001);
                chk("t3_wready_low", dma_wready, 0);
            end
            tick();
        end
        #3;
        chk("t3_done", dma_done, 1);
        chk("t3_done_stall", cpu_stall, 0);
        tick();
        dma_wvalid = 1'b0;
        cpu_req = 1'b0;

        // CPU byte store with a same-cycle read start, then read the merged word back
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h20; cpu_wdata = 32'h1234_56AB; cpu_strobe = 2'd1;
        start(1'b0, 32'h20, 9'd1);
        #3;
        chk("t4_strobe", mem_strobe, 1);
        chk("t4_we", mem_we, 1);
        chk("t4_stall", cpu_stall, 0);
        chk("t4_addr", mem_addr, 32'h20);
        tick();
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_strobe = 2'd0;
        dma_start = 1'b0;
        #3;
        chk("t4_busy", dma_busy, 1);
        chk("t4_read_addr", mem_addr, 32'h20);
        tick();
        chk("t4_rvalid", dma_rvalid, 1);
        chk("t4_rdata", dma_rdata, 32'hDEAD_BEAB);
        chk("t4_done", dma_done, 1);
        tick();

        // zero-length burst
        start(1'b1, 32'h40, 9'd0);
        dma_wvalid = 1'b1;
        tick();
        dma_start = 1'b0;
        #3;
        chk("t5_done", dma_done, 1);
        chk("t5_we", mem_we, 0);
        chk("t5_wready", dma_wready, 0);
        tick();
        chk("t5_done_off", dma_done, 0);
        chk("t5_busy_off", dma_busy, 0);

        // reset during the second beat of a 4-word write
        start(1'b1, 32'h50, 9'd4);
        tick();
        dma_start = 1'b0;
        dma_wdata = 32'hE000_0000;
        #3;
        chk("t6_beat0_we", mem_we, 1);
        tick();
        dma_wdata = 32'hE000_0001;
        #1;
        rst = 1'b0;
        #1;
        chk("t6_rst_busy", dma_busy, 0);
        chk("t6_rst_we", mem_we, 0);
        chk("t6_rst_wready", dma_wready, 0);
        chk("t6_rst_done", dma_done, 0);
        tick();
        chk("t6_hold_done", dma_done, 0);
        rst = 1'b1;
        dma_wvalid = 1'b0;
        start(1'b0, 32'h50, 9'd2);
        tick();
        dma_start = 1'b0;
        tick();
        chk("t6_rd0_valid", dma_rvalid, 1);
        chk("t6_rd0_data", dma_rdata, 32'hE000_0000);
        tick();
        chk("t6_rd1_data", dma_rdata, 32'hDEAD_BE00);
        chk("t6_new_done", dma_done, 1);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
